// File: rtl/pkt_operand_streamer_if.sv
// pkt_operand_streamer_if: packet-in / operand-pair-out bus with scoreboard counters
interface pkt_operand_streamer_if #(
    parameter int PKT_W  = 2048,
    parameter int DATA_W = 8
);
    localparam int MAX_PAIRS = PKT_W / (2 * DATA_W);
    localparam int LEN_W     = $clog2(MAX_PAIRS + 1);
    logic [PKT_W-1:0]  pkt_i;
    logic [LEN_W-1:0]  pkt_len_i;
    logic              pkt_valid_i;
    logic              pkt_ready_o;
    logic [DATA_W-1:0] A_s;
    logic [DATA_W-1:0] B_s;
    logic              op_valid_o;
    logic              op_ready_i;
    logic [15:0]       pkt_cnt_o;
    logic [31:0]       pair_cnt_o;
    modport master (
        output pkt_i, pkt_len_i, pkt_valid_i, op_ready_i,
        input  pkt_ready_o, A_s, B_s, op_valid_o, pkt_cnt_o, pair_cnt_o
    );
    modport slave (
        input  pkt_i, pkt_len_i, pkt_valid_i, op_ready_i,
        output pkt_ready_o, A_s, B_s, op_valid_o, pkt_cnt_o, pair_cnt_o
    );
endinterface

// File: rtl/pkt_operand_streamer.sv
// pkt_operand_streamer: serialises a wide packet into (A,B) operand pairs, LSB pair first
module pkt_operand_streamer #(
    parameter int PKT_W  = 2048,
    parameter int DATA_W = 8
) (
    input logic                    clk_i,
    input logic                    reset_i,
    pkt_operand_streamer_if.slave  bus
);
    localparam int MAX_PAIRS = PKT_W / (2 * DATA_W);
    localparam int LEN_W     = $clog2(MAX_PAIRS + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAIRS);
    typedef enum logic {IDLE, SEND} state_t;
    state_t            state, state_nxt;
    logic [PKT_W-1:0]  buffer;
    logic [LEN_W-1:0]  idx, len, len_in;
    logic [15:0]       pkt_cnt;
    logic [31:0]       pair_cnt;
    logic              accept, fire, last;
    assign len_in = (bus.pkt_len_i > MAX_LEN) ? MAX_LEN : bus.pkt_len_i;
    assign accept = (state == IDLE) && bus.pkt_valid_i;
    assign fire   = (state == SEND) && bus.op_ready_i;
    assign last   = idx == len - LEN_W'(1);
    assign bus.pkt_cnt_o  = pkt_cnt;
    assign bus.pair_cnt_o = pair_cnt;
    // state, packet buffer (shifted one pair per transfer) and counters
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= IDLE;
            idx      <= '0;
            len      <= '0;
            buffer   <= '0;
            pkt_cnt  <= '0;
            pair_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                buffer  <= bus.pkt_i;
                len     <= len_in;
                idx     <= '0;
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (fire) begin
                buffer   <= buffer >> (2 * DATA_W);
                idx      <= idx + LEN_W'(1);
                pair_cnt <= pair_cnt + 32'd1;
            end
        end
    end
    // a zero-length packet is consumed in IDLE; SEND leaves after the last pair is taken
    always_comb begin
        state_nxt = (state == IDLE) ? ((bus.pkt_valid_i && len_in != '0) ? SEND : IDLE)
                                    : ((bus.op_ready_i && last) ? IDLE : SEND);
    end
    // outputs come straight from registers; ready is held low while reset is asserted
    always_comb begin
        bus.pkt_ready_o = (state == IDLE) && !reset_i;
        bus.op_valid_o  = state == SEND;
        bus.A_s         = (state == SEND) ? buffer[DATA_W-1:0] : '0;
        bus.B_s         = (state == SEND) ? buffer[2*DATA_W-1:DATA_W] : '0;
    end
endmodule
